// File: rtl/rca_pg_seq_ctrl_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller.
//   SEGW     : bits handled by the shared slice per cycle
//   state_e  : controller FSM states
//   nseg()   : number of segments for a given operand width
package rca_pg_seq_ctrl_pkg;

  localparam int unsigned SEGW = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned nseg(int unsigned width);
    return width / SEGW;
  endfunction

endpackage

// File: rtl/rca_pg_seq_ctrl_if.sv
// Request/response bundle of the sequential adder.
//   master : operand source and result sink (drives in_valid/a/b/ci/approx_segs/out_ready)
//   slave  : the adder (drives in_ready/out_valid/sum/cout/approx_hit)
interface rca_pg_seq_ctrl_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNTW  = 3
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [CNTW-1:0]  approx_segs;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             approx_hit;

  modport master (
    output in_valid, a, b, ci, approx_segs, out_ready,
    input  in_ready, out_valid, sum, cout, approx_hit
  );

  modport slave (
    input  in_valid, a, b, ci, approx_segs, out_ready,
    output in_ready, out_valid, sum, cout, approx_hit
  );

endinterface

// File: rtl/rca_pg_3b.sv
// 3-bit ripple-carry slice with group propagate/generate.
//   a_i, b_i : operand bits
//   c_i      : carry-in
//   s_o      : sum bits (uses c_i)
//   p_o      : group propagate (all bits propagate)
//   g_o      : group generate (carry-out independent of c_i)
module rca_pg_3b (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic       c_i,
  output logic [2:0] s_o,
  output logic       p_o,
  output logic       g_o
);

  logic [2:0] pb;
  logic [2:0] gb;
  logic [2:0] c;

  assign pb = a_i ^ b_i;
  assign gb = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = gb[0] | (pb[0] & c[0]);
  assign c[2] = gb[1] | (pb[1] & c[1]);

  assign s_o = pb ^ c;
  assign p_o = &pb;
  assign g_o = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/rca_pg_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 3-bit slice processes a segment per cycle, LSB first.
// The low approx_segs segments pass only the group generate as carry (p&cin dropped);
// approx_hit flags that a dropped term was 1, i.e. the result differs from exact.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
module rca_pg_seq_ctrl
  import rca_pg_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNTW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  rca_pg_seq_ctrl_if.slave  bus
);

  localparam int unsigned    NSEG    = nseg(WIDTH);
  localparam logic [CNTW-1:0] LastSeg = CNTW'(NSEG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNTW-1:0]  k_q, k_d, seg_cnt_q, seg_cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             hit_q, hit_d, out_valid_q, out_valid_d;

  logic [SEGW-1:0]  slice_s;
  logic             slice_p, slice_g;
  logic             approx, carry_sel;

  rca_pg_3b u_slice (
    .a_i (a_q[SEGW-1:0]),
    .b_i (b_q[SEGW-1:0]),
    .c_i (carry_q),
    .s_o (slice_s),
    .p_o (slice_p),
    .g_o (slice_g)
  );

  assign approx    = seg_cnt_q < k_q;
  assign carry_sel = approx ? slice_g : (slice_g | (slice_p & carry_q));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    seg_cnt_d   = seg_cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    hit_d       = hit_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d         = bus.a;
          b_d         = bus.b;
          carry_d     = bus.ci;
          k_d         = bus.approx_segs;
          seg_cnt_d   = '0;
          sum_d       = '0;
          hit_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        carry_d   = carry_sel;
        if (approx) hit_d = hit_q | (slice_p & carry_q);
        // Each new segment enters at the top; after NSEG shifts segment 0 sits at bit 0.
        sum_d     = {slice_s, sum_q[WIDTH-1:SEGW]};
        a_d       = a_q >> SEGW;
        b_d       = b_q >> SEGW;
        seg_cnt_d = seg_cnt_q + 1'b1;
        if (seg_cnt_q == LastSeg) begin
          cout_d      = carry_sel;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      seg_cnt_q   <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      hit_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      seg_cnt_q   <= seg_cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      hit_q       <= hit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = out_valid_q;
  assign bus.sum        = sum_q;
  assign bus.cout       = cout_q;
  assign bus.approx_hit = hit_q;

endmodule
